// File: rtl/vga_board_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_board_renderer_if
// Purpose  : Ready/valid cell-write port from the game logic to the renderer.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_board_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_cell;
  logic [1:0] wr_mark;

  modport master (
    output wr_valid,
    output wr_cell,
    output wr_mark,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_cell,
    input  wr_mark,
    output wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/vga_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_board_renderer
// Purpose  : Per-pixel colour-select for a 3x3 tic-tac-toe board with marks and
//            cursor; board writes commit at frame start. Macro: CURSOR_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_board_renderer #(
  parameter int SELECT_SIZE  = 3,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int CELL_PX      = 120,
  parameter int X_OFF        = 140,
  parameter int Y_OFF        = 60,
  parameter int LINE_PX      = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int MARK_INSET   = 20,
  parameter int X_HALF_W     = 3,
  parameter int O_THICK      = 6
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_i,
  input  wire logic                   inActiveArea_i,
  input  wire logic                   vsync_i,
  vga_board_renderer_if.slave         wr_if,
  input  wire logic [3:0]             cursor_i,
  output logic      [SELECT_SIZE-1:0] select_o,
  output logic                        inActiveArea_o
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int UW = $clog2(CELL_PX);
  localparam int SW = UW + 1;

  localparam logic [XW-1:0] c_X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] c_Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] c_X_BEG   = XW'(X_OFF);
  localparam logic [XW-1:0] c_X_END   = XW'(X_OFF + 3 * CELL_PX);
  localparam logic [YW-1:0] c_Y_BEG   = YW'(Y_OFF);
  localparam logic [YW-1:0] c_Y_END   = YW'(Y_OFF + 3 * CELL_PX);
  localparam logic [UW-1:0] c_U_LAST  = UW'(CELL_PX - 1);
  localparam logic [UW-1:0] c_LINE    = UW'(LINE_PX);
  localparam logic [UW-1:0] c_BAND_HI = UW'(CELL_PX - LINE_PX);
  localparam logic [UW-1:0] c_MK_LO   = UW'(MARK_INSET);
  localparam logic [UW-1:0] c_MK_HI   = UW'(CELL_PX - MARK_INSET - 1);
  localparam logic [UW-1:0] c_OIN_LO  = UW'(MARK_INSET + O_THICK);
  localparam logic [UW-1:0] c_OIN_HI  = UW'(CELL_PX - MARK_INSET - O_THICK - 1);
  localparam logic [SW-1:0] c_XH      = SW'(X_HALF_W);
  localparam logic [SW-1:0] c_ANTI_LO = SW'(CELL_PX - 1 - X_HALF_W);
  localparam logic [SW-1:0] c_ANTI_HI = SW'(CELL_PX - 1 + X_HALF_W);

  localparam logic [SELECT_SIZE-1:0] c_SEL_NONE   = SELECT_SIZE'(0);
  localparam logic [SELECT_SIZE-1:0] c_SEL_GRID   = SELECT_SIZE'(1);
  localparam logic [SELECT_SIZE-1:0] c_SEL_X      = SELECT_SIZE'(2);
  localparam logic [SELECT_SIZE-1:0] c_SEL_O      = SELECT_SIZE'(3);
  localparam logic [SELECT_SIZE-1:0] c_SEL_CURSOR = SELECT_SIZE'(4);

  logic          r_vsync_d;
  logic          w_frame_start;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [UW-1:0] r_u;
  logic [UW-1:0] r_v;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic          w_in_x;
  logic          w_in_y;

  assign w_frame_start = r_vsync_d & ~vsync_i;
  assign w_in_x        = (r_x >= c_X_BEG) && (r_x < c_X_END);
  assign w_in_y        = (r_y >= c_Y_BEG) && (r_y < c_Y_END);

  // u/col and v/row are only meaningful inside the board span; they idle at 0
  // outside it so they start aligned on the first board pixel/line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vsync_d <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_u       <= '0;
      r_v       <= '0;
      r_col     <= 2'd0;
      r_row     <= 2'd0;
    end else begin
      r_vsync_d <= vsync_i;
      if (w_frame_start) begin
        r_x   <= '0;
        r_y   <= '0;
        r_u   <= '0;
        r_v   <= '0;
        r_col <= 2'd0;
        r_row <= 2'd0;
      end else if (inActiveArea_i) begin
        if (r_x == c_X_LAST) begin
          r_x   <= '0;
          r_u   <= '0;
          r_col <= 2'd0;
          r_y   <= (r_y == c_Y_LAST) ? '0 : r_y + YW'(1);
          if (!w_in_y) begin
            r_v   <= '0;
            r_row <= 2'd0;
          end else if (r_v == c_U_LAST) begin
            r_v   <= '0;
            r_row <= (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
          end else begin
            r_v <= r_v + UW'(1);
          end
        end else begin
          r_x <= r_x + XW'(1);
          if (!w_in_x) begin
            r_u   <= '0;
            r_col <= 2'd0;
          end else if (r_u == c_U_LAST) begin
            r_u   <= '0;
            r_col <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
          end else begin
            r_u <= r_u + UW'(1);
          end
        end
      end
    end
  end

  logic w_blink_on;

`ifdef CURSOR_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_on;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_start) begin
      if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  assign w_blink_on = r_blink_on;
`else
  assign w_blink_on = 1'b1;
`endif

  logic       r_pend;
  logic [3:0] r_pcell;
  logic [1:0] r_pmark;
  logic       w_accept;
  logic       w_commit;
  logic [1:0] r_board [9];

  assign wr_if.wr_ready = ~r_pend;
  assign w_accept       = wr_if.wr_valid & ~r_pend;
  assign w_commit       = w_frame_start & r_pend;

  // A write accepted on the frame-start cycle sees r_pend=0, so it is not
  // committed until the following frame start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend  <= 1'b0;
      r_pcell <= 4'd0;
      r_pmark <= 2'b00;
    end else if (w_commit) begin
      r_pend <= 1'b0;
    end else if (w_accept) begin
      r_pend  <= 1'b1;
      r_pcell <= wr_if.wr_cell;
      r_pmark <= wr_if.wr_mark;
    end
  end

  // Out-of-range cell indices match no entry and are dropped here.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 9; i++) begin
      if (rst_i) begin
        r_board[i] <= 2'b00;
      end else if (w_commit && (r_pcell == 4'(i))) begin
        r_board[i] <= r_pmark;
      end
    end
  end

  logic [3:0]    w_cell_idx;
  logic [1:0]    w_mark;
  logic [SW-1:0] w_u_ext;
  logic [SW-1:0] w_v_ext;
  logic [SW-1:0] w_sum;
  logic          w_grid;
  logic          w_band;
  logic          w_cursor;
  logic          w_zone;
  logic          w_o_inner;
  logic          w_diag;
  logic          w_anti;
  logic          w_x_px;
  logic          w_o_px;
  logic [SELECT_SIZE-1:0] w_sel;

  assign w_cell_idx = {1'b0, r_row, 1'b0} + {2'b00, r_row} + {2'b00, r_col};

  always_comb begin
    w_mark = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (w_cell_idx == 4'(i)) begin
        w_mark = r_board[i];
      end
    end
  end

  assign w_u_ext   = {1'b0, r_u};
  assign w_v_ext   = {1'b0, r_v};
  assign w_sum     = w_u_ext + w_v_ext;
  assign w_grid    = ((r_u < c_LINE) && (r_col != 2'd0)) ||
                     ((r_v < c_LINE) && (r_row != 2'd0));
  assign w_band    = (r_u < c_LINE) || (r_u >= c_BAND_HI) ||
                     (r_v < c_LINE) || (r_v >= c_BAND_HI);
  assign w_cursor  = w_band && (cursor_i == w_cell_idx) && w_blink_on;
  assign w_zone    = (r_u >= c_MK_LO) && (r_u <= c_MK_HI) &&
                     (r_v >= c_MK_LO) && (r_v <= c_MK_HI);
  assign w_o_inner = (r_u >= c_OIN_LO) && (r_u <= c_OIN_HI) &&
                     (r_v >= c_OIN_LO) && (r_v <= c_OIN_HI);
  // |u-v| <= X_HALF_W written without subtraction to stay unsigned.
  assign w_diag    = (w_u_ext + c_XH >= w_v_ext) && (w_v_ext + c_XH >= w_u_ext);
  assign w_anti    = (w_sum >= c_ANTI_LO) && (w_sum <= c_ANTI_HI);
  assign w_x_px    = (w_mark == 2'b01) && w_zone && (w_diag || w_anti);
  assign w_o_px    = (w_mark == 2'b10) && w_zone && !w_o_inner;

  always_comb begin
    w_sel = c_SEL_NONE;
    if (inActiveArea_i && w_in_x && w_in_y) begin
      if (w_grid) begin
        w_sel = c_SEL_GRID;
      end else if (w_cursor) begin
        w_sel = c_SEL_CURSOR;
      end else if (w_x_px) begin
        w_sel = c_SEL_X;
      end else if (w_o_px) begin
        w_sel = c_SEL_O;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      select_o       <= c_SEL_NONE;
      inActiveArea_o <= 1'b0;
    end else begin
      select_o       <= w_sel;
      inActiveArea_o <= inActiveArea_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_board_renderer
// Purpose  : Reduced-geometry bench for vga_board_renderer against a pixel-level
//            reference model; honours CURSOR_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_board_renderer;
  localparam int H   = 48;
  localparam int V   = 40;
  localparam int C   = 12;
  localparam int XO  = 5;
  localparam int YO  = 3;
  localparam int L   = 2;
  localparam int BF  = 3;
  localparam int INS = 3;
  localparam int XH  = 1;
  localparam int OT  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       act;
  logic       vs;
  logic [3:0] cursor;
  logic [2:0] sel;
  logic       act_o;

  vga_board_renderer_if wr_if ();

  vga_board_renderer #(
    .SELECT_SIZE (3),  .H_ACTIVE (H),  .V_ACTIVE (V),  .CELL_PX (C),
    .X_OFF (XO),       .Y_OFF (YO),    .LINE_PX (L),   .BLINK_FRAMES (BF),
    .MARK_INSET (INS), .X_HALF_W (XH), .O_THICK (OT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .inActiveArea_i (act),
    .vsync_i        (vs),
    .wr_if          (wr_if),
    .cursor_i       (cursor),
    .select_o       (sel),
    .inActiveArea_o (act_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: pixel position, display board, pending slot, blink.
  int mx, my;
  int board [9];
  bit pend;
  int pcell, pmark;
  int bcnt;
  bit bon;
  bit vs_prev;

  function automatic int iabs(input int d);
    return (d < 0) ? -d : d;
  endfunction

  function automatic int ref_sel(input int x, input int y, input bit a, input int cur);
    int col, row, u, v, idx, m;
    bit band, zone, inner;
    if (!a) return 0;
    if (x < XO || x >= XO + 3 * C || y < YO || y >= YO + 3 * C) return 0;
    col = (x - XO) / C;
    u   = (x - XO) % C;
    row = (y - YO) / C;
    v   = (y - YO) % C;
    idx = row * 3 + col;
    m   = board[idx];
    if ((u < L && col > 0) || (v < L && row > 0)) return 1;
    band = (u < L) || (u >= C - L) || (v < L) || (v >= C - L);
    if (band && cur == idx && bon) return 4;
    zone  = (u >= INS) && (u < C - INS) && (v >= INS) && (v < C - INS);
    inner = (u >= INS + OT) && (u < C - INS - OT) && (v >= INS + OT) && (v < C - INS - OT);
    if (m == 1 && zone && (iabs(u - v) <= XH || iabs(u + v - (C - 1)) <= XH)) return 2;
    if (m == 2 && zone && !inner) return 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input int x, input int y,
                     input logic [3:0] obs, input logic [3:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s at (%0d,%0d) t=%0t: got %0d expected %0d", tag, x, y, $time, obs, expv);
    end
  endtask

  task automatic step(input bit r, input bit a, input bit v, input bit wv,
                      input int wc, input int wm, input int cur);
    int  esel, ex, ey;
    bit  eact, erdy, fs, acc, com;
    rst            = r;
    act            = a;
    vs             = v;
    wr_if.wr_valid = wv;
    wr_if.wr_cell  = 4'(wc);
    wr_if.wr_mark  = 2'(wm);
    cursor         = 4'(cur);
    ex = mx;
    ey = my;
    if (r) begin
      esel = 0; eact = 0;
      mx = 0; my = 0;
      foreach (board[i]) board[i] = 0;
      pend = 0; bcnt = 0; bon = 1; vs_prev = 0;
    end else begin
      esel = ref_sel(mx, my, a, cur);
      eact = a;
      fs   = vs_prev && !v;
      acc  = wv && !pend;
      com  = fs && pend;
      if (fs) begin
        mx = 0; my = 0;
      end else if (a) begin
        mx++;
        if (mx == H) begin
          mx = 0;
          my = (my == V - 1) ? 0 : my + 1;
        end
      end
      if (com) begin
        if (pcell <= 8) board[pcell] = pmark;
        pend = 0;
      end else if (acc) begin
        pend = 1; pcell = wc; pmark = wm;
      end
`ifdef CURSOR_BLINK_EN
      if (fs) begin
        bcnt++;
        if (bcnt == BF) begin
          bcnt = 0;
          bon  = !bon;
        end
      end
`endif
      vs_prev = v;
    end
    erdy = !pend;
    @(posedge clk);
    #1;
    chk("select_o", ex, ey, {1'b0, sel}, 4'(esel));
    chk("inActiveArea_o", ex, ey, {3'b000, act_o}, {3'b000, eact});
    chk("wr_ready_o", ex, ey, {3'b000, wr_if.wr_ready}, {3'b000, erdy});
  endtask

  task automatic run_pixels(input int count, input int wr_pct, input int cur);
    int n;
    n = 0;
    while (n < count) begin
      bit a, wv;
      a  = ($urandom_range(0, 7) != 0);
      wv = ($urandom_range(0, 99) < wr_pct);
      step(0, a, 1, wv, $urandom_range(0, 15), $urandom_range(0, 3), cur);
      if (a) n++;
    end
  endtask

  task automatic vblank(input int cur, input bit wv_fs, input int wc, input int wm);
    step(0, 0, 1, 0, 0, 0, cur);
    step(0, 0, 1, 0, 0, 0, cur);
    step(0, 0, 0, wv_fs, wc, wm, cur);
    step(0, 0, 0, 0, 0, 0, cur);
    step(0, 0, 1, 0, 0, 0, cur);
    step(0, 0, 1, 0, 0, 0, cur);
  endtask

  initial begin
    rst = 1'b1; act = 1'b0; vs = 1'b1; cursor = 4'd15;
    wr_if.wr_valid = 1'b0; wr_if.wr_cell = 4'd0; wr_if.wr_mark = 2'b00;

    // Reset, then the first active pixels at the top-left corner.
    repeat (3) step(1, 0, 1, 0, 0, 0, 15);
    step(0, 1, 1, 0, 0, 0, 15);
    step(0, 0, 1, 0, 0, 0, 15);
    step(0, 1, 1, 0, 0, 0, 15);

    // Mid-frame write of X into the centre cell; shows only after frame start.
    run_pixels(H * V / 2 - 2, 0, 15);
    step(0, 1, 1, 1, 4, 1, 15);
    run_pixels(H * V / 2 - 1, 0, 15);
    vblank(15, 0, 0, 0);

    // Out-of-range cell, then mark 11 on cell 0, then O on cell 8 at frame start.
    step(0, 1, 1, 1, 9, 1, 15);
    run_pixels(H * V - 1, 0, 15);
    vblank(15, 0, 0, 0);
    step(0, 1, 1, 1, 0, 3, 15);
    run_pixels(H * V - 1, 0, 15);
    vblank(15, 1, 8, 2);
    run_pixels(H * V, 0, 15);
    vblank(15, 0, 0, 0);
    run_pixels(H * V, 0, 8);
    vblank(8, 0, 0, 0);

    // Randomised frames: sparse writes, random cursor (including none).
    for (int f = 0; f < 5; f++) begin
      int cur;
      cur = $urandom_range(0, 15);
      run_pixels(H * V, 2, cur);
      vblank(cur, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 3));
    end

    // Reset mid-line with a write pending.
    run_pixels(H * (YO + 4) + 17, 0, 4);
    step(0, 1, 1, 1, 2, 2, 4);
    run_pixels(10, 0, 4);
    step(1, 1, 1, 0, 0, 0, 4);
    run_pixels(H * V, 0, 4);
    vblank(4, 0, 0, 0);
    run_pixels(H * V, 0, 4);
    vblank(4, 0, 0, 0);

    // Cursor on cell 0 across two blink half-periods.
    for (int f = 0; f < 2 * BF + 1; f++) begin
      run_pixels(H * V, 0, 0);
      vblank(0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
